// File: rtl/audio_frame_fifo_pkg.sv
// Shared audio FIFO constants, frame type and a width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_frame_fifo_pkg;

    localparam int AUDIO_CHANNELS  = 2;
    localparam int AUDIO_SAMPLE_W  = 24;
    localparam int AUDIO_FIFO_SIZE = 56;

    typedef logic [AUDIO_CHANNELS*AUDIO_SAMPLE_W-1:0] audio_frame_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/audio_frame_fifo_if.sv
// Write/pop/status bundle between register bank, playback path and the frame FIFO.
// Latency: n/a (wires only).
// Backpressure: none; producers watch full_out/level_out, overflow/nodata are sticky.
interface audio_frame_fifo_if import audio_frame_fifo_pkg::*; #(
    parameter int CHANNELS = AUDIO_CHANNELS,
    parameter int WIDTH    = AUDIO_SAMPLE_W,
    parameter int DEPTH    = AUDIO_FIFO_SIZE
) ();
    localparam int CH_W  = clog2_min1(CHANNELS);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                      wr_in;
    logic [CH_W-1:0]           wr_ch_in;
    logic [WIDTH-1:0]          wdata_in;
    logic                      rd_req_in;
    logic [LVL_W-1:0]          threshold_in;
    logic [CHANNELS*WIDTH-1:0] rdata_out;
    logic                      rvalid_out;
    logic                      nodata_out;
    logic                      overflow_out;
    logic [CHANNELS-1:0]       full_out;
    logic [LVL_W-1:0]          level_out;
    logic                      lowlevel_irq_out;

    modport master (
        output wr_in, wr_ch_in, wdata_in, rd_req_in, threshold_in,
        input  rdata_out, rvalid_out, nodata_out, overflow_out, full_out,
               level_out, lowlevel_irq_out
    );

    modport slave (
        input  wr_in, wr_ch_in, wdata_in, rd_req_in, threshold_in,
        output rdata_out, rvalid_out, nodata_out, overflow_out, full_out,
               level_out, lowlevel_irq_out
    );

endinterface

// File: rtl/audio_frame_fifo_chan_buf.sv
// Single-channel circular sample buffer: own write pointer and count, shared external read pointer.
// Latency: write visible in count/full one cycle later; read data is combinational from rptr.
// Backpressure: writes into a full buffer are dropped and reported on ovf_hit.
module audio_frame_fifo_chan_buf import audio_frame_fifo_pkg::*; #(
    parameter int  WIDTH = AUDIO_SAMPLE_W,
    parameter int  DEPTH = AUDIO_FIFO_SIZE,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic [PTR_W-1:0] rptr,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] cnt_nxt,
    output logic             full,
    output logic             ovf_hit
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             wr_ok;

    // Accept/drop decision on the pre-edge count, then next pointer/count.
    always_comb begin
        wr_ok   = wr_en && (cnt_q != LVL_W'(DEPTH));
        ovf_hit = wr_en && (cnt_q == LVL_W'(DEPTH));
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        if (clr) begin
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            end
            case ({wr_ok, pop})
                2'b10:   cnt_d = cnt_q + LVL_W'(1);
                2'b01:   cnt_d = cnt_q - LVL_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        full_d = (cnt_d == LVL_W'(DEPTH));
    end

    // Pointer, count and full flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // Sample storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wptr_q] <= wdata;
        end
    end

    assign rdata   = mem[rptr];
    assign cnt_nxt = cnt_d;
    assign full    = full_q;

endmodule

// File: rtl/audio_frame_fifo.sv
// Multi-channel audio FIFO: per-channel pushes, whole-frame pops through one shared read pointer.
// Latency: 1 clk from rd_req_in to rvalid_out/rdata_out; level/full valid the cycle after an event.
// Backpressure: none; full writes set sticky overflow, empty pops return silence and set sticky nodata.
module audio_frame_fifo import audio_frame_fifo_pkg::*; #(
    parameter int CHANNELS = AUDIO_CHANNELS,
    parameter int WIDTH    = AUDIO_SAMPLE_W,
    parameter int DEPTH    = AUDIO_FIFO_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_in,
    audio_frame_fifo_if.slave   bus
);

    localparam int CH_W  = clog2_min1(CHANNELS);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = clog2_min1(DEPTH);

    logic [CHANNELS-1:0]       wr_en;
    logic [CHANNELS-1:0]       full_vec;
    logic [CHANNELS-1:0]       ovf_vec;
    logic [CHANNELS*WIDTH-1:0] chan_rdata;
    logic [LVL_W-1:0]          cnt_nxt [CHANNELS];

    logic [PTR_W-1:0]          rptr_q, rptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic [CHANNELS*WIDTH-1:0] rdata_q, rdata_d;
    logic                      rvalid_q, rvalid_d;
    logic                      nodata_q, nodata_d;
    logic                      overflow_q, overflow_d;
    logic                      irq_q, irq_d;
    logic                      pop;
    logic                      underrun;

    // Pops are decided on the registered (pre-edge) level; clear wins.
    assign pop      = !clr_in && bus.rd_req_in && (level_q != '0);
    assign underrun = !clr_in && bus.rd_req_in && (level_q == '0);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Out-of-range channel numbers match no buffer and are silently ignored.
        assign wr_en[c] = bus.wr_in && (bus.wr_ch_in == CH_W'(c));

        audio_frame_fifo_chan_buf #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr_in),
            .wr_en   (wr_en[c]),
            .wdata   (bus.wdata_in),
            .pop     (pop),
            .rptr    (rptr_q),
            .rdata   (chan_rdata[c*WIDTH +: WIDTH]),
            .cnt_nxt (cnt_nxt[c]),
            .full    (full_vec[c]),
            .ovf_hit (ovf_vec[c])
        );
    end

    // Next read pointer, frame level (minimum of next counts), output data and flags.
    always_comb begin
        rptr_d     = rptr_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        nodata_d   = nodata_q;
        overflow_d = overflow_q;
        irq_d      = 1'b0;

        level_d = cnt_nxt[0];
        for (int c = 1; c < CHANNELS; c++) begin
            if (cnt_nxt[c] < level_d) begin
                level_d = cnt_nxt[c];
            end
        end

        if (clr_in) begin
            rptr_d     = '0;
            rdata_d    = '0;
            nodata_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (|ovf_vec) begin
                overflow_d = 1'b1;
            end
            if (pop) begin
                rptr_d   = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
                rdata_d  = chan_rdata;
                rvalid_d = 1'b1;
                nodata_d = 1'b0;
                irq_d    = (level_d == bus.threshold_in) &&
                           (bus.threshold_in < LVL_W'(DEPTH));
            end else if (underrun) begin
                rdata_d  = '0;
                nodata_d = 1'b1;
            end
        end
    end

    // Shared read-side state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q     <= '0;
            level_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            nodata_q   <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            nodata_q   <= nodata_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.rdata_out        = rdata_q;
    assign bus.rvalid_out       = rvalid_q;
    assign bus.nodata_out       = nodata_q;
    assign bus.overflow_out     = overflow_q;
    assign bus.full_out         = full_vec;
    assign bus.level_out        = level_q;
    assign bus.lowlevel_irq_out = irq_q;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Self-checking bench for audio_frame_fifo: directed scenarios plus randomized traffic vs. a queue model.
// Latency: checks sample outputs on the falling edge after each active edge.
// Backpressure: n/a.
module tb_audio_frame_fifo;
    import audio_frame_fifo_pkg::*;

    localparam int CH = 2;
    localparam int W  = 24;
    localparam int D  = 56;
    localparam int LW = $clog2(D + 1);

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clr_in = 1'b0;

    always #5 clk = ~clk;

    audio_frame_fifo_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) bus ();

    audio_frame_fifo #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_in (clr_in),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel, frames popped from the fronts.
    logic [W-1:0] mq0[$];
    logic [W-1:0] mq1[$];
    audio_frame_t exp_rdata;
    logic exp_rvalid, exp_nodata, exp_ovf, exp_irq;

    function automatic int mlevel();
        return (mq0.size() < mq1.size()) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [1:0] mfull();
        return {mq1.size() == D, mq0.size() == D};
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        exp_rdata  = '0;
        exp_rvalid = 1'b0;
        exp_nodata = 1'b0;
        exp_ovf    = 1'b0;
        exp_irq    = 1'b0;
    endtask

    task automatic model_edge(input logic wr, input logic ch, input logic [W-1:0] d,
                              input logic rd, input logic clr, input int thr);
        int   lvl;
        logic pop, wr_ok;
        logic [W-1:0] s0, s1;
        if (clr) begin
            model_reset();
            return;
        end
        lvl        = mlevel();
        pop        = rd && (lvl > 0);
        wr_ok      = wr && ((ch == 1'b0) ? (mq0.size() < D) : (mq1.size() < D));
        exp_rvalid = 1'b0;
        exp_irq    = 1'b0;
        if (wr && !wr_ok) exp_ovf = 1'b1;
        if (pop) begin
            s0 = mq0.pop_front();
            s1 = mq1.pop_front();
            exp_rdata  = {s1, s0};
            exp_rvalid = 1'b1;
            exp_nodata = 1'b0;
        end else if (rd) begin
            exp_rdata  = '0;
            exp_nodata = 1'b1;
        end
        if (wr_ok) begin
            if (ch == 1'b0) mq0.push_back(d);
            else            mq1.push_back(d);
        end
        if (pop && thr < D && mlevel() == thr) exp_irq = 1'b1;
    endtask

    // One clock of stimulus; returns on the following falling edge.
    task automatic step(input logic wr, input logic ch, input logic [W-1:0] d,
                        input logic rd, input logic clr);
        bus.wr_in     = wr;
        bus.wr_ch_in  = ch;
        bus.wdata_in  = d;
        bus.rd_req_in = rd;
        clr_in        = clr;
        @(posedge clk);
        model_edge(wr, ch, d, rd, clr, int'(bus.threshold_in));
        @(negedge clk);
        bus.wr_in     = 1'b0;
        bus.rd_req_in = 1'b0;
        clr_in        = 1'b0;
    endtask

    task automatic test_reset();
        bus.wr_in = 0; bus.wr_ch_in = 0; bus.wdata_in = 0; bus.rd_req_in = 0; bus.threshold_in = 5;
        model_reset();
        #1;
        checks++; if (bus.rdata_out !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_out); end
        checks++; if (bus.rvalid_out !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid_out); end
        checks++; if (bus.level_out !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level_out); end
        checks++; if ({bus.nodata_out, bus.overflow_out, bus.lowlevel_irq_out, bus.full_out} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {bus.nodata_out, bus.overflow_out, bus.lowlevel_irq_out, bus.full_out}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        step(1, 0, 24'h000011, 0, 0);
        step(1, 1, 24'h000022, 0, 0);
        checks++; if (bus.level_out !== LW'(1)) begin errors++; $display("FAIL basic_level1: got %0d want 1", bus.level_out); end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.rvalid_out !== 1'b1) begin errors++; $display("FAIL basic_rvalid: got %b want 1", bus.rvalid_out); end
        checks++; if (bus.rdata_out !== 48'h000022_000011) begin errors++; $display("FAIL basic_rdata: got %h want 000022000011", bus.rdata_out); end
        checks++; if (bus.level_out !== '0) begin errors++; $display("FAIL basic_level0: got %0d want 0", bus.level_out); end
        checks++; if (bus.lowlevel_irq_out !== 1'b0) begin errors++; $display("FAIL basic_irq: got %b want 0", bus.lowlevel_irq_out); end
        step(0, 0, 0, 0, 0);
        checks++; if (bus.rvalid_out !== 1'b0) begin errors++; $display("FAIL basic_rvalid_pulse: got %b want 0", bus.rvalid_out); end
        checks++; if (bus.rdata_out !== 48'h000022_000011) begin errors++; $display("FAIL basic_rdata_hold: got %h want 000022000011", bus.rdata_out); end
    endtask

    task automatic test_overflow();
        logic [2*W-1:0] e;
        for (int i = 0; i < D; i++) step(1, 0, W'(32'h500 + i), 0, 0);
        checks++; if (bus.full_out !== 2'b01) begin errors++; $display("FAIL ovf_full: got %b want 01", bus.full_out); end
        checks++; if (bus.level_out !== '0) begin errors++; $display("FAIL ovf_level: got %0d want 0", bus.level_out); end
        checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", bus.overflow_out); end
        step(1, 0, 24'hABCDEF, 0, 0);
        checks++; if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_out); end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.nodata_out !== 1'b1) begin errors++; $display("FAIL ovf_nodata: got %b want 1", bus.nodata_out); end
        checks++; if (bus.rdata_out !== '0) begin errors++; $display("FAIL ovf_silence: got %h want 0", bus.rdata_out); end
        checks++; if (bus.rvalid_out !== 1'b0) begin errors++; $display("FAIL ovf_rvalid: got %b want 0", bus.rvalid_out); end
        for (int i = 0; i < D; i++) step(1, 1, W'(32'h700 + i), 0, 0);
        for (int i = 0; i < D; i++) begin
            step(0, 0, 0, 1, 0);
            e = {W'(32'h700 + i), W'(32'h500 + i)};
            checks++; if (bus.rvalid_out !== 1'b1 || bus.rdata_out !== e) begin
                errors++; $display("FAIL ovf_drain[%0d]: got v=%b %h want v=1 %h", i, bus.rvalid_out, bus.rdata_out, e); end
        end
        checks++; if (bus.nodata_out !== 1'b0 || bus.overflow_out !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got nodata=%b ovf=%b want 0 1", bus.nodata_out, bus.overflow_out); end
    endtask

    task automatic test_wrap();
        logic [2*W-1:0] e;
        step(0, 0, 0, 0, 1);
        step(1, 0, 24'h0000AA, 0, 0);
        step(1, 1, 24'h0000BB, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int n = 0; n < D; n++) begin
            step(1, 0, W'(n), 0, 0);
            step(1, 1, W'(32'h100 + n), 0, 0);
        end
        checks++; if (bus.full_out !== 2'b11 || bus.level_out !== LW'(D)) begin
            errors++; $display("FAIL wrap_full: got full=%b level=%0d want 11 %0d", bus.full_out, bus.level_out, D); end
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 0, 1, 0);
            if (i < D) begin
                e = {W'(32'h100 + i), W'(i)};
                checks++; if (bus.rvalid_out !== 1'b1 || bus.rdata_out !== e) begin
                    errors++; $display("FAIL wrap_pop[%0d]: got v=%b %h want v=1 %h", i, bus.rvalid_out, bus.rdata_out, e); end
            end else begin
                checks++; if (bus.rvalid_out !== 1'b0 || bus.nodata_out !== 1'b1 || bus.rdata_out !== '0) begin
                    errors++; $display("FAIL wrap_under[%0d]: got v=%b nd=%b %h want 0 1 0", i, bus.rvalid_out, bus.nodata_out, bus.rdata_out); end
            end
        end
    endtask

    task automatic test_irq();
        step(0, 0, 0, 0, 1);
        bus.threshold_in = 3;
        for (int n = 0; n < 5; n++) begin
            step(1, 0, W'(n), 0, 0);
            step(1, 1, W'(n), 0, 0);
        end
        checks++; if (bus.level_out !== LW'(5) || bus.lowlevel_irq_out !== 1'b0) begin
            errors++; $display("FAIL irq_fill: got level=%0d irq=%b want 5 0", bus.level_out, bus.lowlevel_irq_out); end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.lowlevel_irq_out !== 1'b0) begin errors++; $display("FAIL irq_pop1: got %b want 0", bus.lowlevel_irq_out); end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.lowlevel_irq_out !== 1'b1 || bus.level_out !== LW'(3)) begin
            errors++; $display("FAIL irq_pop2: got irq=%b level=%0d want 1 3", bus.lowlevel_irq_out, bus.level_out); end
        step(0, 0, 0, 0, 0);
        checks++; if (bus.lowlevel_irq_out !== 1'b0) begin errors++; $display("FAIL irq_pulse_width: got %b want 0", bus.lowlevel_irq_out); end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.lowlevel_irq_out !== 1'b0 || bus.level_out !== LW'(2)) begin
            errors++; $display("FAIL irq_pop3: got irq=%b level=%0d want 0 2", bus.lowlevel_irq_out, bus.level_out); end
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        checks++; if (bus.lowlevel_irq_out !== 1'b0 || bus.level_out !== LW'(3)) begin
            errors++; $display("FAIL irq_write: got irq=%b level=%0d want 0 3", bus.lowlevel_irq_out, bus.level_out); end
    endtask

    task automatic test_simul();
        step(0, 0, 0, 0, 1);
        bus.threshold_in = 10;
        step(1, 0, 24'h000001, 0, 0);
        step(1, 1, 24'h000002, 0, 0);
        step(1, 1, 24'h000033, 1, 0);
        checks++; if (bus.rvalid_out !== 1'b1 || bus.rdata_out !== 48'h000002_000001) begin
            errors++; $display("FAIL simul_pop: got v=%b %h want v=1 000002000001", bus.rvalid_out, bus.rdata_out); end
        checks++; if (bus.level_out !== '0 || bus.full_out !== 2'b00) begin
            errors++; $display("FAIL simul_level: got level=%0d full=%b want 0 00", bus.level_out, bus.full_out); end
        step(1, 0, 24'h000044, 0, 0);
        checks++; if (bus.level_out !== LW'(1)) begin errors++; $display("FAIL simul_cnt1: got %0d want 1", bus.level_out); end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.rdata_out !== 48'h000033_000044) begin errors++; $display("FAIL simul_data: got %h want 000033000044", bus.rdata_out); end
    endtask

    task automatic test_clear();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        for (int n = 0; n < 4; n++) begin
            step(1, 0, W'(n + 9), 0, 0);
            step(1, 1, W'(n + 9), 0, 0);
        end
        checks++; if (bus.level_out !== LW'(4) || bus.nodata_out !== 1'b1) begin
            errors++; $display("FAIL clr_pre: got level=%0d nodata=%b want 4 1", bus.level_out, bus.nodata_out); end
        step(1, 0, 24'h0000FF, 1, 1);
        checks++; if (bus.level_out !== '0 || bus.rvalid_out !== 1'b0 || bus.rdata_out !== '0) begin
            errors++; $display("FAIL clr_state: got level=%0d v=%b %h want 0 0 0", bus.level_out, bus.rvalid_out, bus.rdata_out); end
        checks++; if ({bus.nodata_out, bus.overflow_out, bus.lowlevel_irq_out, bus.full_out} !== 5'b0) begin
            errors++; $display("FAIL clr_flags: got %b want 00000", {bus.nodata_out, bus.overflow_out, bus.lowlevel_irq_out, bus.full_out}); end
    endtask

    task automatic test_rst_mid();
        for (int n = 0; n < 3; n++) begin
            step(1, 0, W'(n + 1), 0, 0);
            step(1, 1, W'(n + 1), 0, 0);
        end
        step(0, 0, 0, 1, 0);
        checks++; if (bus.rvalid_out !== 1'b1 || bus.level_out !== LW'(2)) begin
            errors++; $display("FAIL rst_pre: got v=%b level=%0d want 1 2", bus.rvalid_out, bus.level_out); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.rvalid_out !== 1'b0 || bus.rdata_out !== '0 || bus.level_out !== '0) begin
            errors++; $display("FAIL rst_async: got v=%b %h level=%0d want 0 0 0", bus.rvalid_out, bus.rdata_out, bus.level_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic wr, rd, clr, ch;
        int   phase_wr;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            phase_wr = ((cyc / 300) % 2 == 0) ? 80 : 25;
            if (cyc % 97 == 0) bus.threshold_in = LW'($urandom_range(0, D + 2));
            wr  = ($urandom_range(0, 99) < phase_wr);
            rd  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 499) == 0);
            ch  = 1'($urandom_range(0, 1));
            step(wr, ch, W'($urandom), rd, clr);
            checks++; if (bus.rdata_out !== exp_rdata || bus.rvalid_out !== exp_rvalid) begin
                errors++; $display("FAIL rnd_data[%0d]: got v=%b %h want v=%b %h", cyc, bus.rvalid_out, bus.rdata_out, exp_rvalid, exp_rdata); end
            checks++; if (bus.level_out !== LW'(mlevel()) || bus.full_out !== mfull()) begin
                errors++; $display("FAIL rnd_level[%0d]: got level=%0d full=%b want %0d %b", cyc, bus.level_out, bus.full_out, mlevel(), mfull()); end
            checks++; if ({bus.nodata_out, bus.overflow_out, bus.lowlevel_irq_out} !== {exp_nodata, exp_ovf, exp_irq}) begin
                errors++; $display("FAIL rnd_flags[%0d]: got nd/ovf/irq=%b want %b", cyc,
                    {bus.nodata_out, bus.overflow_out, bus.lowlevel_irq_out}, {exp_nodata, exp_ovf, exp_irq}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_irq();
        test_simul();
        test_clear();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
